ll_fifo_drain: RTL and testbench

// Pop-side reader for the shared linked_list_fifo. Round-robins across its NUM_FIFOS queues, issues
// pop/pop_sel only to non-empty enabled queues, and hands popped words downstream on a valid/ready

---
 rtl/ll_fifo_drain.sv | 116 +++++++++++
 tb/tb_ll_fifo_drain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_fifo_drain.sv
// Pop-side reader for the shared linked-list FIFO: round-robin grant over non-empty enabled queues,
// feeding a 2-entry in-order buffer that drives a valid/ready downstream port.
module ll_fifo_drain #(
    parameter  int WIDTH     = 8,
    parameter  int NUM_FIFOS = 2,
    localparam int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     ll_data,
    input  logic [NUM_FIFOS-1:0] enable,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [SEL_WIDTH-1:0] m_sel,
    output logic                 busy
);

    localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH+1)'(NUM_FIFOS);

    // Modulo-NUM_FIFOS add; NUM_FIFOS need not be a power of two, so the wrap is explicit.
    function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                      input logic [SEL_WIDTH:0]   offset);
        logic [SEL_WIDTH:0] sum;
        sum = {1'b0, base} + offset;
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        return sum[SEL_WIDTH-1:0];
    endfunction

    logic [NUM_FIFOS-1:0] cand;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] grant;
    logic [SEL_WIDTH-1:0] cand_idx;
    logic                 grant_valid;

    logic [1:0]           count;
    logic [WIDTH-1:0]     data0;
    logic [WIDTH-1:0]     data1;
    logic [SEL_WIDTH-1:0] sel0;
    logic [SEL_WIDTH-1:0] sel1;
    logic                 accept;
    logic                 room;

    assign cand = ~empty & enable;

    // Scan from the farthest offset back to rr_ptr so the nearest candidate wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_ptr;
        cand_idx    = rr_ptr;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            cand_idx = wrap_add(rr_ptr, (SEL_WIDTH+1)'(i));
            if (cand[cand_idx]) begin
                grant_valid = 1'b1;
                grant       = cand_idx;
            end
        end
    end

    assign m_valid = (count != 2'd0);
    assign m_data  = data0;
    assign m_sel   = sel0;
    assign accept  = m_valid & m_ready;
    assign room    = (count < 2'd2) | accept;
    assign pop     = grant_valid & room & rst;
    assign pop_sel = grant;
    assign busy    = m_valid | (|cand);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= 2'd0;
            rr_ptr <= '0;
        end else begin
            if (pop) begin
                rr_ptr <= wrap_add(grant, (SEL_WIDTH+1)'(1));
            end
            case ({pop, accept})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Slot 0 is always the head; slot 1 only ever holds the word behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data0 <= '0;
            sel0  <= '0;
            data1 <= '0;
            sel1  <= '0;
        end else begin
            if (accept && count == 2'd2) begin
                data0 <= data1;
                sel0  <= sel1;
            end else if (pop && (count == 2'd0 || (count == 2'd1 && accept))) begin
                data0 <= ll_data;
                sel0  <= grant;
            end
            if (pop && ((count == 2'd1 && !accept) || (count == 2'd2 && accept))) begin
                data1 <= ll_data;
                sel1  <= grant;
            end
        end
    end

    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst) pop |-> !empty[pop_sel]);
    a_pop_enabled:  assert property (@(posedge clk) disable iff (!rst) pop |-> enable[pop_sel]);
    a_count_range:  assert property (@(posedge clk) disable iff (!rst) count <= 2'd2);

endmodule

// File: tb/tb_ll_fifo_drain.sv
// Directed bench for ll_fifo_drain: a 2-queue instance backed by a small shared-FIFO model,
// plus a 3-queue instance driven directly for the skip/wrap case.
module tb_ll_fifo_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] empty;
    logic [7:0] ll_data;
    logic [1:0] enable;
    logic       pop;
    logic [0:0] pop_sel;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [0:0] m_sel;
    logic       busy;

    logic [2:0] empty3;
    logic [7:0] ll_data3;
    logic [2:0] enable3;
    logic       pop3;
    logic [1:0] pop_sel3;
    logic       m_valid3;
    logic       m_ready3;
    logic [7:0] m_data3;
    logic [1:0] m_sel3;
    logic       busy3;

    int ntests = 0;
    int nfail  = 0;

    // Shared FIFO model: two queues in a ring memory, popped by the DUT.
    logic [7:0] mem [2][16];
    int rd [2];
    int wr [2];

    always #5 clk = ~clk;

    always @(posedge clk) if (pop) rd[pop_sel] <= rd[pop_sel] + 1;

    assign empty[0] = (rd[0] == wr[0]);
    assign empty[1] = (rd[1] == wr[1]);
    assign ll_data  = mem[pop_sel][rd[pop_sel] % 16];
    assign ll_data3 = {6'b110000, pop_sel3};

    ll_fifo_drain #(.WIDTH(8), .NUM_FIFOS(2)) dut (
        .clk(clk), .rst(rst), .empty(empty), .ll_data(ll_data), .enable(enable),
        .pop(pop), .pop_sel(pop_sel), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_sel(m_sel), .busy(busy)
    );

    ll_fifo_drain #(.WIDTH(8), .NUM_FIFOS(3)) dut3 (
        .clk(clk), .rst(rst), .empty(empty3), .ll_data(ll_data3), .enable(enable3),
        .pop(pop3), .pop_sel(pop_sel3), .m_valid(m_valid3), .m_ready(m_ready3),
        .m_data(m_data3), .m_sel(m_sel3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int q, input logic [7:0] d);
        mem[q][wr[q] % 16] = d;
        wr[q] = wr[q] + 1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        wr[0]    = rd[0];
        wr[1]    = rd[1];
        enable   = 2'b11;
        m_ready  = 1'b1;
        empty3   = 3'b111;
        enable3  = 3'b000;
        m_ready3 = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        push(0, 8'h11);
        push(1, 8'h21);
        #1;
        ntests++; if (pop !== 1'b0) begin nfail++; $display("FAIL reset_pop got %0b want 0", pop); end
        ntests++; if (m_valid !== 1'b0) begin nfail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        ntests++; if (m_data !== 8'h00) begin nfail++; $display("FAIL reset_m_data got %h want 00", m_data); end
        rst = 1'b1;
        #1;
        ntests++; if (pop !== 1'b1) begin nfail++; $display("FAIL release_pop got %0b want 1", pop); end
        ntests++; if (pop_sel !== 1'b0) begin nfail++; $display("FAIL release_pop_sel got %0d want 0", pop_sel); end
        tick();
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            nfail++; $display("FAIL release_first_word got v=%0b d=%h want v=1 d=11", m_valid, m_data);
        end
    endtask

    task automatic test_round_robin();
        logic [0:0] exp_sel;
        logic [7:0] exp_data;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            push(0, 8'hA0 + 8'(j));
            push(1, 8'hB0 + 8'(j));
        end
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_sel = 1'(k % 2);
            ntests++; if (pop !== 1'b1 || pop_sel !== exp_sel) begin
                nfail++; $display("FAIL rr_pop k=%0d got pop=%0b sel=%0d want pop=1 sel=%0d", k, pop, pop_sel, exp_sel);
            end
            if (k > 0) begin
                exp_data = (((k - 1) % 2) == 1) ? 8'hB0 + 8'((k - 1) / 2) : 8'hA0 + 8'((k - 1) / 2);
                ntests++; if (m_valid !== 1'b1 || m_sel !== 1'((k - 1) % 2) || m_data !== exp_data) begin
                    nfail++; $display("FAIL rr_out k=%0d got v=%0b sel=%0d d=%h want v=1 sel=%0d d=%h",
                                      k, m_valid, m_sel, m_data, (k - 1) % 2, exp_data);
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(0, 8'hC1);
        push(0, 8'hC2);
        push(0, 8'hC3);
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        ntests++; if (pop !== 1'b1 || pop_sel !== 1'b0) begin nfail++; $display("FAIL bp_pop_a got pop=%0b sel=%0d want 1/0", pop, pop_sel); end
        tick();
        ntests++; if (pop !== 1'b1 || m_data !== 8'hC1) begin nfail++; $display("FAIL bp_pop_b got pop=%0b d=%h want 1/c1", pop, m_data); end
        tick();
        ntests++; if (pop !== 1'b0) begin nfail++; $display("FAIL bp_full_pop got %0b want 0", pop); end
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'hC1) begin nfail++; $display("FAIL bp_full_head got v=%0b d=%h want 1/c1", m_valid, m_data); end
        tick();
        ntests++; if (pop !== 1'b0 || m_data !== 8'hC1 || busy !== 1'b1) begin
            nfail++; $display("FAIL bp_hold got pop=%0b d=%h busy=%0b want 0/c1/1", pop, m_data, busy);
        end
        m_ready = 1'b1;
        #1;
        ntests++; if (pop !== 1'b1 || pop_sel !== 1'b0) begin nfail++; $display("FAIL bp_accept_pop got pop=%0b sel=%0d want 1/0", pop, pop_sel); end
        tick();
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'hC2 || pop !== 1'b0) begin
            nfail++; $display("FAIL bp_second got v=%0b d=%h pop=%0b want 1/c2/0", m_valid, m_data, pop);
        end
        tick();
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'hC3) begin nfail++; $display("FAIL bp_third got v=%0b d=%h want 1/c3", m_valid, m_data); end
        tick();
        ntests++; if (m_valid !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL bp_drained got v=%0b busy=%0b want 0/0", m_valid, busy); end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        empty3  = 3'b110;
        enable3 = 3'b111;
        rst = 1'b1;
        #1;
        ntests++; if (pop3 !== 1'b1 || pop_sel3 !== 2'd0) begin nfail++; $display("FAIL wrap_prime got pop=%0b sel=%0d want 1/0", pop3, pop_sel3); end
        tick();
        empty3 = 3'b010;
        #1;
        ntests++; if (pop3 !== 1'b1 || pop_sel3 !== 2'd2) begin nfail++; $display("FAIL wrap_skip got pop=%0b sel=%0d want 1/2", pop3, pop_sel3); end
        tick();
        ntests++; if (pop3 !== 1'b1 || pop_sel3 !== 2'd0) begin nfail++; $display("FAIL wrap_around got pop=%0b sel=%0d want 1/0", pop3, pop_sel3); end
        ntests++; if (m_sel3 !== 2'd2 || m_data3 !== 8'hC2) begin nfail++; $display("FAIL wrap_out2 got sel=%0d d=%h want 2/c2", m_sel3, m_data3); end
        tick();
        ntests++; if (pop3 !== 1'b1 || pop_sel3 !== 2'd2) begin nfail++; $display("FAIL wrap_again got pop=%0b sel=%0d want 1/2", pop3, pop_sel3); end
        ntests++; if (m_sel3 !== 2'd0 || m_data3 !== 8'hC0) begin nfail++; $display("FAIL wrap_out0 got sel=%0d d=%h want 0/c0", m_sel3, m_data3); end
        enable3 = 3'b000;
    endtask

    task automatic test_enable();
        do_reset();
        push(1, 8'hD1);
        enable = 2'b01;
        rst = 1'b1;
        #1;
        ntests++; if (pop !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL en_masked got pop=%0b busy=%0b want 0/0", pop, busy); end
        enable = 2'b11;
        #1;
        ntests++; if (pop !== 1'b1 || pop_sel !== 1'b1 || busy !== 1'b1) begin
            nfail++; $display("FAIL en_open got pop=%0b sel=%0d busy=%0b want 1/1/1", pop, pop_sel, busy);
        end
        tick();
        ntests++; if (m_valid !== 1'b1 || m_sel !== 1'b1 || m_data !== 8'hD1) begin
            nfail++; $display("FAIL en_word got v=%0b sel=%0d d=%h want 1/1/d1", m_valid, m_sel, m_data);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        push(0, 8'hE1);
        push(0, 8'hE2);
        m_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'hE1 || pop !== 1'b0) begin
            nfail++; $display("FAIL mid_full got v=%0b d=%h pop=%0b want 1/e1/0", m_valid, m_data, pop);
        end
        push(0, 8'hE3);
        push(1, 8'hF1);
        #2;
        rst = 1'b0;
        #1;
        ntests++; if (m_valid !== 1'b0 || m_data !== 8'h00 || pop !== 1'b0) begin
            nfail++; $display("FAIL mid_async got v=%0b d=%h pop=%0b want 0/00/0", m_valid, m_data, pop);
        end
        tick();
        rst = 1'b1;
        #1;
        ntests++; if (m_valid !== 1'b0 || pop !== 1'b1 || pop_sel !== 1'b0) begin
            nfail++; $display("FAIL mid_release got v=%0b pop=%0b sel=%0d want 0/1/0", m_valid, pop, pop_sel);
        end
        tick();
        ntests++; if (m_valid !== 1'b1 || m_data !== 8'hE3 || m_sel !== 1'b0) begin
            nfail++; $display("FAIL mid_first got v=%0b d=%h sel=%0d want 1/e3/0", m_valid, m_data, m_sel);
        end
    endtask

    initial begin
        rd[0] = 0;
        rd[1] = 0;
        wr[0] = 0;
        wr[1] = 0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_enable();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
